imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MEM_SIZE, default 1024, meaning instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter INST_WIDTH, default 32, meaning instruction word width.
REQ-003 The block SHALL have port clk_i  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start_i  input  1  one-cycle pulse that begins a load.
REQ-006 The block SHALL have port byte_i  input  8  incoming stream byte.
REQ-007 The block SHALL have port byte_valid_i  input  1  byte_i valid.
REQ-008 The block SHALL have port byte_ready_o  output  1  block accepts byte_i.
REQ-009 The block SHALL have port mem_we_o  output  1  instruction-memory write strobe.
REQ-010 The block SHALL have port mem_addr_o  output  $clog2(MEM_SIZE)+2  word-aligned byte address.
REQ-011 The block SHALL have port mem_wdata_o  output  INST_WIDTH  write data.
REQ-012 The block SHALL have port core_hold_o  output  1  holds the core in stall while loading.
REQ-013 The block SHALL have port done_o  output  1  load completed successfully (level).
REQ-014 The block SHALL have port err_o  output  1  load aborted on error (level).

Function
REQ-015 The FSM SHALL have states IDLE, LEN, DATA, WRITE, CHK, DONE, ERR.
REQ-016 A byte SHALL transfer only on a cycle where byte_valid_i and byte_ready_o are both high.
REQ-017 byte_ready_o SHALL be high in LEN, DATA and CHK only; it SHALL be low in IDLE, WRITE, DONE and ERR.
REQ-018 In IDLE, DONE or ERR, start_i SHALL clear done_o and err_o, zero the byte, word and address counters, and enter LEN. In any other state, start_i SHALL be ignored.
REQ-019 In LEN, four bytes SHALL be assembled little-endian into word count N.
REQ-020 After the 4th LEN byte, the FSM SHALL go to DONE if N==0, to ERR if N>MEM_SIZE, and otherwise to DATA.
REQ-021 In DATA, four bytes SHALL be assembled little-endian; the cycle after the 4th byte is accepted, the FSM SHALL be in WRITE.
REQ-022 In WRITE, mem_we_o SHALL be high for exactly one cycle, with mem_addr_o = 4*word_index and mem_wdata_o = the assembled word.
REQ-023 The word index SHALL increment after each WRITE and SHALL never wrap.
REQ-024 After the WRITE of word N-1, the FSM SHALL go to CHK if LOADER_CHECKSUM_EN is defined and to DONE otherwise; after any other WRITE it SHALL go to DATA.
REQ-025 core_hold_o SHALL be high in all states except IDLE and DONE, so a failed load keeps the core stalled.
REQ-026 mem_we_o SHALL never be high outside WRITE.
REQ-027 Gaps in byte_valid_i SHALL stall the assembly with no loss of state.

Reset
REQ-028 Asserting rst_n_i SHALL immediately force the FSM to IDLE and clear all counters and the data register.
REQ-029 Reset values SHALL be: byte_ready_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_hold_o=0, done_o=0, err_o=0.
REQ-030 A reset asserted mid-load SHALL abandon the load; words already written SHALL remain in memory.

Configuration
REQ-031 With macro LOADER_CHECKSUM_EN defined, the block SHALL keep a 32-bit running sum (mod 2^32) of the written words, receive a 4-byte little-endian trailer in CHK, and go to DONE on match and ERR on mismatch.
REQ-032 Without LOADER_CHECKSUM_EN, the CHK state and the sum logic SHALL be absent, and the FSM SHALL go from the last WRITE straight to DONE.

Verification
REQ-033 Start; stream N=2, then 0x00000013 and 0x00100093 -> two mem_we_o pulses at addr 0x0 and 0x4 with those data; done_o=1; core_hold_o=0.
REQ-034 Start; N=0 -> DONE after the 4th length byte; no mem_we_o pulses.
REQ-035 Start; N=MEM_SIZE+1 -> err_o=1, core_hold_o=1, no writes; a new start_i clears err_o.
REQ-036 Insert a 5-cycle byte_valid_i gap inside a data word -> same data written; byte_ready_o=0 during WRITE.
REQ-037 Assert rst_n_i after 3 words of N=8 -> all outputs at reset values immediately; a fresh load then succeeds.
REQ-038 With LOADER_CHECKSUM_EN: words 0x1 and 0x2 with trailer 0x3 -> done_o=1; same words with trailer 0x4 -> err_o=1.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed little-endian byte image into instruction memory while stalling the core
// Ports: clk_i/rst_n_i (async active-low), start_i load pulse, byte_i/byte_valid_i/byte_ready_o byte stream,
//        mem_we_o/mem_addr_o/mem_wdata_o memory write port, core_hold_o stall, done_o/err_o status levels.
// Optional: define LOADER_CHECKSUM_EN to require a 32-bit additive checksum trailer after the data words.
module imem_loader #(
  parameter int MEM_SIZE   = 1024,
  parameter int INST_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic [7:0]                    byte_i,
  input  logic                          byte_valid_i,
  output logic                          byte_ready_o,
  output logic                          mem_we_o,
  output logic [$clog2(MEM_SIZE)+1:0]   mem_addr_o,
  output logic [INST_WIDTH-1:0]         mem_wdata_o,
  output logic                          core_hold_o,
  output logic                          done_o,
  output logic                          err_o
);
  localparam int IW = $clog2(MEM_SIZE);
  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CHK, DONE, ERR} state_t;
  state_t        state;
  logic [1:0]    cnt;
  logic [31:0]   data;
  logic [31:0]   len;
  logic [IW-1:0] idx;
  logic [31:0]   word;
  logic          fire;
  logic          last;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]   sum;
`endif
  assign fire = byte_valid_i & byte_ready_o;
  // bytes arrive LSB first, so shifting in from the top leaves a little-endian word after four bytes
  assign word = {byte_i, data[31:8]};
  assign last = 32'(idx) == len - 32'd1;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
      data  <= '0;
      len   <= '0;
      idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE, ERR: if (start_i) begin
          state <= LEN;
          cnt   <= '0;
          data  <= '0;
          idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
          sum   <= '0;
`endif
        end
        LEN: if (fire) begin
          cnt  <= cnt + 2'd1;
          data <= word;
          if (cnt == 2'd3) begin
            len   <= word;
            state <= word == '0 ? DONE : word > 32'(MEM_SIZE) ? ERR : DATA;
          end
        end
        DATA: if (fire) begin
          cnt  <= cnt + 2'd1;
          data <= word;
          if (cnt == 2'd3) state <= WRITE;
        end
        WRITE: begin
          // hold the index on the final word so it can never wrap past the memory
          idx <= last ? idx : idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          sum   <= sum + data;
          state <= last ? CHK : DATA;
`else
          state <= last ? DONE : DATA;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (fire) begin
          cnt  <= cnt + 2'd1;
          data <= word;
          if (cnt == 2'd3) state <= word == sum ? DONE : ERR;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
  assign byte_ready_o = state == LEN || state == DATA || state == CHK;
  assign mem_we_o     = state == WRITE;
  assign mem_addr_o   = {idx, 2'b00};
  assign mem_wdata_o  = INST_WIDTH'(data);
  assign core_hold_o  = !(state == IDLE || state == DONE);
  assign done_o       = state == DONE;
  assign err_o        = state == ERR;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader
module tb_imem_loader;
  localparam int MS = 16;
  localparam int AW = $clog2(MS) + 2;
  logic clk = 0, rst_n = 0, start = 0, bv = 0;
  logic [7:0] b = 0;
  logic br, we, hold, done, err;
  logic [AW-1:0] addr;
  logic [31:0] wdata;
  int checks = 0, errors = 0;
  logic [63:0] sb[$];
  logic [63:0] e_m;
  logic [31:0] wq[$];
  int gap_lo = 0, gap_hi = 0;
  bit poke = 0, corrupt = 0;

  imem_loader #(.MEM_SIZE(MS), .INST_WIDTH(32)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .byte_i(b), .byte_valid_i(bv),
    .byte_ready_o(br), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
    .core_hold_o(hold), .done_o(done), .err_o(err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      chk("ready_in_write", 32'(br), 32'd0);
      if (sb.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e_m = sb.pop_front();
        chk("waddr", 32'(addr), e_m[63:32]);
        chk("wdata", wdata, e_m[31:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] v);
    int t = 0;
    repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
    @(negedge clk);
    b = v;
    bv = 1;
    while (!br && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!br) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 bv = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic load(input logic [31:0] n);
    logic [31:0] sum = 0;
    bit exp_err;
    int t = 0;
    exp_err = n > MS;
    pulse_start();
    chk("start_clr_done", 32'(done), 32'd0);
    chk("start_clr_err", 32'(err), 32'd0);
    chk("start_hold", 32'(hold), 32'd1);
    send_word(n);
    if (n != 0 && !exp_err) begin
      for (int i = 0; i < int'(n); i++) begin
        sb.push_back({32'(4 * i), wq[i]});
        sum += wq[i];
        send_word(wq[i]);
        if (poke && i == 0) pulse_start();
      end
`ifdef LOADER_CHECKSUM_EN
      send_word(sum + 32'(corrupt));
      exp_err = corrupt;
`endif
    end
    while (!(done || err) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("done", 32'(done), 32'(!exp_err));
    chk("err", 32'(err), 32'(exp_err));
    chk("hold", 32'(hold), 32'(exp_err));
    chk("sb_empty", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic fill(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back($urandom());
  endtask

  task automatic chk_reset_outputs();
    chk("rst_flags", {27'd0, br, we, hold, done, err}, 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #12;
    chk_reset_outputs();
    @(negedge clk) rst_n = 1;
    wq.delete();
    wq.push_back(32'h0000_0013);
    wq.push_back(32'h0010_0093);
    load(2);
    load(0);
    load(MS + 1);
    load(32'hFFFF_FFFF);
    gap_lo = 5; gap_hi = 5;
    fill(3);
    load(3);
    gap_lo = 0; gap_hi = 0;
    fill(MS);
    load(MS);
    poke = 1;
    fill(4);
    load(4);
    poke = 0;
    for (int k = 0; k < 6; k++) begin
      int n;
      gap_hi = $urandom_range(0, 3);
      n = $urandom_range(1, MS);
      fill(n);
      load(n);
    end
    gap_hi = 0;
    fill(8);
    pulse_start();
    send_word(32'd8);
    for (int i = 0; i < 3; i++) begin
      sb.push_back({32'(4 * i), wq[i]});
      send_word(wq[i]);
    end
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_sb_empty", sb.size(), 32'd0);
    #2 rst_n = 0;
    #1 chk_reset_outputs();
    @(negedge clk) rst_n = 1;
    fill(5);
    load(5);
`ifdef LOADER_CHECKSUM_EN
    wq.delete();
    wq.push_back(32'h1);
    wq.push_back(32'h2);
    corrupt = 0;
    load(2);
    corrupt = 1;
    load(2);
    corrupt = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
